// File: rtl/sram22_param_model.sv
// Behavioural SRAM macro model: masked writes, 1- or 2-stage read pipeline,
// optional write-through and a zero-fill sweep after reset.
module sram22_param_model #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned MASK_GRAN     = 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_THROUGH = 0,
  parameter int unsigned INIT_CLEAR    = 1,
  localparam int unsigned WMASK_WIDTH  = DATA_WIDTH / MASK_GRAN
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   rvalid,
  output logic                   busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam bit          WT_EN = (WRITE_THROUGH != 0);
  localparam bit          CLR_EN = (INIT_CLEAR != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept_c;
  logic                    wr_acc_c;
  logic                    rd_acc_c;
  logic [DATA_WIDTH-1:0]   bmask_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;
  logic [DATA_WIDTH-1:0]   merged_c;
  logic                    load_c;
  logic [DATA_WIDTH-1:0]   load_data_c;
  logic                    out_valid_c;
  logic [DATA_WIDTH-1:0]   out_data_c;

  // Request acceptance: only when enabled and not sweeping.
  assign accept_c = ce & ~busy;
  assign wr_acc_c = accept_c & we;
  assign rd_acc_c = accept_c & ~we;

  // Expand lane mask to a bit mask.
  always_comb begin
    bmask_c = '0;
    for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
      bmask_c[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask[i]}};
    end
  end

  // Current word and its post-write merge; unmasked lanes keep old data.
  assign rd_word_c = mem[addr];
  assign merged_c  = (rd_word_c & ~bmask_c) | (din & bmask_c);

  // A beat enters the read pipeline on a read, or on a write when write-through.
  assign load_c      = rd_acc_c | (wr_acc_c & WT_EN);
  assign load_data_c = we ? merged_c : rd_word_c;

  // Sweep / idle state machine with the busy flag kept in lockstep.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= CLR_EN ? ST_CLEAR : ST_IDLE;
      busy    <= CLR_EN;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; cleared only by the sweep, never by reset.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc_c) begin
      mem[addr] <= merged_c;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      // Extra stage between the array and the output register.
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= load_c;
          if (load_c) begin
            s1_data <= load_data_c;
          end
        end
      end

      assign out_valid_c = s1_valid;
      assign out_data_c  = s1_data;
    end else begin : g_lat1
      assign out_valid_c = load_c;
      assign out_data_c  = load_data_c;
    end
  endgenerate

  // Output register: dout only moves when a valid beat leaves the pipe.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      rvalid <= out_valid_c;
      if (out_valid_c) begin
        dout <= out_data_c;
      end
    end
  end

endmodule

// File: doc/sram22_param_model.md
SRAM22_PARAM_MODEL -- requirements
Module: sram22_param_model

Interface
REQ-001 Parameter DATA_WIDTH, default 16: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; depth = 2^ADDR_WIDTH words.
REQ-003 Parameter MASK_GRAN, default 8: bits per write-mask lane; DATA_WIDTH SHALL be a multiple of MASK_GRAN; WMASK_WIDTH = DATA_WIDTH/MASK_GRAN.
REQ-004 Parameter READ_LATENCY, default 1: read pipeline depth; legal values 1 or 2.
REQ-005 Parameter WRITE_THROUGH, default 0: 0 = dout unchanged on write; 1 = write returns merged word on dout.
REQ-006 Parameter INIT_CLEAR, default 1: 1 = zero-fill sweep after reset; 0 = no sweep.
REQ-007 clk  input  1  clock; all state changes on rising edge except reset.
REQ-008 rstb  input  1  reset; asynchronous, active-low.
REQ-009 ce  input  1  chip enable; request accepted only when ce=1 and busy=0.
REQ-010 we  input  1  1 = write, 0 = read.
REQ-011 wmask  input  WMASK_WIDTH  per-lane write enable; bit i covers din[i*MASK_GRAN +: MASK_GRAN].
REQ-012 addr  input  ADDR_WIDTH  word address.
REQ-013 din  input  DATA_WIDTH  write data.
REQ-014 dout  output  DATA_WIDTH  read data, registered.
REQ-015 rvalid  output  1  one-cycle pulse, dout valid in that cycle.
REQ-016 busy  output  1  1 while clear sweep runs; requests ignored.
REQ-017 Under USE_POWER_PINS, inout vdd and vss SHALL be present ahead of clk; no functional effect.

Function
REQ-018 FSM states CLEAR and IDLE; CLEAR entered on reset when INIT_CLEAR=1, else IDLE.
REQ-019 In CLEAR: ADDR_WIDTH-bit counter writes zero to mem[counter] each cycle, increments; on counter = 2^ADDR_WIDTH-1 write, next state IDLE, counter wraps to 0.
REQ-020 busy = 1 exactly while state = CLEAR; sweep takes 2^ADDR_WIDTH cycles after rstb rises.
REQ-021 Accepted write: for each lane i with wmask[i]=1, mem[addr] lane i <= din lane i; other lanes unchanged; wmask=0 -> no change.
REQ-022 Accepted write, WRITE_THROUGH=0: no rvalid; dout holds previous value.
REQ-023 Accepted write, WRITE_THROUGH=1: read pipeline loaded with merged post-write word; rvalid follows with READ_LATENCY as for a read.
REQ-024 Accepted read: mem[addr] captured at edge N; READ_LATENCY=1 -> dout/rvalid updated at edge N, visible cycle N+1; READ_LATENCY=2 -> at edge N+1, visible cycle N+2.
REQ-025 rvalid high one cycle per accepted read; back-to-back reads give back-to-back rvalid, full throughput, in order.
REQ-026 dout updates only when a valid beat leaves the last stage; otherwise holds.
REQ-027 ce=0, or ce=1 while busy=1: no memory write, no pipeline entry, no rvalid; in-flight beats still drain.
REQ-028 Read of a never-written address after INIT_CLEAR=0 reset returns X in simulation; not checked.
REQ-029 Read of address written at preceding edge returns new data (write completes before next access).

Reset
REQ-030 rstb=0 asynchronously: dout=0, rvalid=0, pipeline valids=0, counter=0, state per REQ-018; busy=INIT_CLEAR.
REQ-031 Reset mid-sweep restarts sweep from address 0 after rstb rises; in-flight reads discarded.
REQ-032 Memory array not reset except via sweep.

Verification
REQ-033 Default params, release rstb, hold ce=1 -> busy=1 for 256 cycles, then 0; read addr 0xFF -> dout=0x0000, rvalid one cycle.
REQ-034 Write addr 0x10 din 0xABCD wmask 2'b01, then read 0x10 -> dout=0x00CD; write din 0x1234 wmask 2'b10, read -> 0x12CD.
REQ-035 READ_LATENCY=2, reads 0x01,0x02,0x03 on consecutive cycles after writing 0x1111,0x2222,0x3333 -> rvalid high 3 cycles starting 2 cycles after first read, data in order.
REQ-036 WRITE_THROUGH=1, write 0x20 din 0xBEEF wmask 2'b11 -> rvalid next cycle, dout=0xBEEF; WRITE_THROUGH=0 same stimulus -> rvalid stays 0.
REQ-037 Assert rstb=0 at sweep cycle 100 -> dout=0, rvalid=0 immediately; after release busy lasts full 256 cycles.
REQ-038 DATA_WIDTH=32, MASK_GRAN=8, write 0xFFFFFFFF wmask 4'b0101 to cleared word -> read 0x00FF00FF.
